// File: rtl/ahb_master_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_burst_ctrl
// Purpose  : AHB-Lite master-side burst sequencer. Takes one burst command per
//            handshake from a local core and drives NONSEQ/SEQ/BUSY/IDLE beats
//            with INCR/WRAP address stepping. Tracks the data phase one beat
//            behind the address phase. Stretches on hready wait states and
//            aborts the burst on a two-cycle ERROR response.
// Options  : `define AHB_BUSY_EN lets i_beat_stall insert BUSY transfers.
//            When it is undefined, i_beat_stall is ignored.
// Ports    : i_hclk / i_hreset           clock, synchronous active-high reset
//            i_req_*  / o_req_ready      burst command handshake
//            i_beat_stall                core pause request (BUSY insertion)
//            i_wdata / o_wdata_pop       write data and per-beat advance pulse
//            o_rdata / o_rdata_valid     read data and per-beat valid pulse
//            o_done / o_done_err         end-of-burst pulse and error qualifier
//            o_h* / i_hready/hresp/hrdata AHB-Lite master port
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master_burst_ctrl #(
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 32,
   parameter int         LEN_W     = 5,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic              i_hclk,
   input  logic              i_hreset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic              i_req_write,
   input  logic [2:0]        i_req_size,
   input  logic [2:0]        i_req_burst,
   input  logic [LEN_W-1:0]  i_req_len,
   input  logic              i_beat_stall,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_wdata_pop,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rdata_valid,
   output logic              o_done,
   output logic              o_done_err,
   output logic [ADDR_W-1:0] o_haddr,
   output logic [1:0]        o_htrans,
   output logic              o_hwrite,
   output logic [2:0]        o_hsize,
   output logic [2:0]        o_hburst,
   output logic [3:0]        o_hprot,
   output logic [DATA_W-1:0] o_hwdata,
   input  logic              i_hready,
   input  logic              i_hresp,
   input  logic [DATA_W-1:0] i_hrdata
);

   localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
   localparam logic [1:0] c_TRANS_BUSY   = 2'b01;
   localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] c_TRANS_SEQ    = 2'b11;

   localparam logic [2:0] c_SIZE_BYTE = 3'd0;
   localparam logic [2:0] c_SIZE_WORD = 3'd2;

   localparam logic [2:0] c_BURST_SINGLE = 3'd0;
   localparam logic [2:0] c_BURST_INCR   = 3'd1;
   localparam logic [2:0] c_BURST_WRAP4  = 3'd2;
   localparam logic [2:0] c_BURST_INCR4  = 3'd3;
   localparam logic [2:0] c_BURST_WRAP8  = 3'd4;
   localparam logic [2:0] c_BURST_INCR8  = 3'd5;
   localparam logic [2:0] c_BURST_WRAP16 = 3'd6;
   localparam logic [2:0] c_BURST_INCR16 = 3'd7;

   // Beat counter must hold both req_len and the fixed 16-beat bursts.
   localparam int c_CNT_W = (LEN_W > 5) ? LEN_W : 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_LAST = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_haddr, w_haddr_nxt;
   logic [1:0]          r_htrans, w_htrans_nxt;
   logic                r_hwrite, w_hwrite_nxt;
   logic [2:0]          r_hsize, w_hsize_nxt;
   logic [2:0]          r_hburst, w_hburst_nxt;
   logic [c_CNT_W-1:0]  r_remain, w_remain_nxt;       // beats still to issue after the current one
   logic [1:0]          r_next_trans, w_next_trans_nxt; // transfer type parked behind a BUSY
   logic                r_dp_valid, w_dp_valid_nxt;   // a data phase is in progress
   logic                r_dp_write, w_dp_write_nxt;
   logic                r_rej, w_rej_nxt;             // rejected command: report it next cycle

   logic                w_stall;
   logic                w_req_bad;
   logic [c_CNT_W-1:0]  w_req_beats;
   logic                w_is_wrap;
   logic [4:0]          w_wrap_beats;
   logic [ADDR_W-1:0]   w_inc;
   logic [ADDR_W-1:0]   w_incr_addr;
   logic [ADDR_W-1:0]   w_wrap_mask;
   logic [ADDR_W-1:0]   w_next_addr;
   logic [1:0]          w_next_kind;
   logic                w_dp_done;

`ifdef AHB_BUSY_EN
   assign w_stall = i_beat_stall;
`else
   logic w_unused_stall;
   assign w_unused_stall = i_beat_stall;
   assign w_stall        = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Command decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_req_beats = c_CNT_W'(1);
      case (i_req_burst)
         c_BURST_INCR:                  w_req_beats = c_CNT_W'(i_req_len);
         c_BURST_WRAP4, c_BURST_INCR4:  w_req_beats = c_CNT_W'(4);
         c_BURST_WRAP8, c_BURST_INCR8:  w_req_beats = c_CNT_W'(8);
         c_BURST_WRAP16, c_BURST_INCR16: w_req_beats = c_CNT_W'(16);
         default:                       w_req_beats = c_CNT_W'(1);
      endcase
   end

   assign w_req_bad = (i_req_size > c_SIZE_WORD) ||
                      ((i_req_burst == c_BURST_INCR) && (i_req_len == '0));

   // -------------------------------------------------------------------------
   // Next-beat address generation from the currently presented beat
   // -------------------------------------------------------------------------
   always_comb begin
      w_is_wrap    = 1'b0;
      w_wrap_beats = 5'd4;
      case (r_hburst)
         c_BURST_WRAP4:  begin w_is_wrap = 1'b1; w_wrap_beats = 5'd4;  end
         c_BURST_WRAP8:  begin w_is_wrap = 1'b1; w_wrap_beats = 5'd8;  end
         c_BURST_WRAP16: begin w_is_wrap = 1'b1; w_wrap_beats = 5'd16; end
         default:        begin w_is_wrap = 1'b0; w_wrap_beats = 5'd4;  end
      endcase
   end

   assign w_inc       = ADDR_W'(1) << r_hsize;
   assign w_incr_addr = r_haddr + w_inc;
   assign w_wrap_mask = (ADDR_W'(w_wrap_beats) << r_hsize) - ADDR_W'(1);
   assign w_next_addr = w_is_wrap ? ((r_haddr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask))
                                  : w_incr_addr;
   // A wrap never leaves its block, so only incrementing bursts can flip bit 10;
   // crossing a 1KB boundary restarts the burst with a NONSEQ.
   assign w_next_kind = (w_next_addr[10] != r_haddr[10]) ? c_TRANS_NONSEQ : c_TRANS_SEQ;

   assign w_dp_done = r_dp_valid && i_hready && !i_hresp;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state, next bus values and status pulses
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_haddr_nxt      = r_haddr;
      w_htrans_nxt     = r_htrans;
      w_hwrite_nxt     = r_hwrite;
      w_hsize_nxt      = r_hsize;
      w_hburst_nxt     = r_hburst;
      w_remain_nxt     = r_remain;
      w_next_trans_nxt = r_next_trans;
      w_dp_valid_nxt   = r_dp_valid;
      w_dp_write_nxt   = r_dp_write;
      w_rej_nxt        = 1'b0;
      o_req_ready      = (r_state == S_IDLE) && !r_rej;
      o_done           = 1'b0;
      o_done_err       = 1'b0;

      case (r_state)
         S_IDLE: begin
            // The cycle reporting a rejection is not an accept cycle, which
            // keeps done and a new accept from ever coinciding.
            if (r_rej) begin
               o_done     = 1'b1;
               o_done_err = 1'b1;
            end
            if (i_req_valid && o_req_ready) begin
               if (w_req_bad) begin
                  w_rej_nxt = 1'b1;
               end else begin
                  w_haddr_nxt  = i_req_addr;
                  w_htrans_nxt = c_TRANS_NONSEQ;
                  w_hwrite_nxt = i_req_write;
                  w_hsize_nxt  = i_req_size;
                  w_hburst_nxt = i_req_burst;
                  w_remain_nxt = w_req_beats - c_CNT_W'(1);
                  w_state_nxt  = S_ADDR;
               end
            end
         end

         S_ADDR: begin
            if (r_dp_valid && i_hresp && !i_hready) begin
               // First ERROR cycle: the pending address phase is withdrawn.
               w_htrans_nxt   = c_TRANS_IDLE;
               w_dp_valid_nxt = 1'b0;
               w_state_nxt    = S_ERR;
            end else if (i_hready) begin
               // BUSY has no data phase behind it.
               w_dp_valid_nxt = (r_htrans == c_TRANS_NONSEQ) || (r_htrans == c_TRANS_SEQ);
               w_dp_write_nxt = r_hwrite;
               if (r_htrans == c_TRANS_BUSY) begin
                  // Address already points at the parked beat.
                  if (!w_stall) begin
                     w_htrans_nxt = r_next_trans;
                  end
               end else if (r_remain == '0) begin
                  w_htrans_nxt = c_TRANS_IDLE;
                  w_state_nxt  = S_LAST;
               end else begin
                  w_haddr_nxt  = w_next_addr;
                  w_remain_nxt = r_remain - c_CNT_W'(1);
                  if (w_stall) begin
                     w_htrans_nxt     = c_TRANS_BUSY;
                     w_next_trans_nxt = w_next_kind;
                  end else begin
                     w_htrans_nxt = w_next_kind;
                  end
               end
            end
         end

         S_LAST: begin
            if (i_hresp && !i_hready) begin
               w_dp_valid_nxt = 1'b0;
               w_state_nxt    = S_ERR;
            end else if (i_hready) begin
               o_done         = !i_hresp;
               w_dp_valid_nxt = 1'b0;
               w_state_nxt    = S_IDLE;
            end
         end

         S_ERR: begin
            if (i_hready) begin
               o_done      = 1'b1;
               o_done_err  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Address/control and data-phase tracking registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         r_haddr      <= '0;
         r_htrans     <= c_TRANS_IDLE;
         r_hwrite     <= 1'b0;
         r_hsize      <= c_SIZE_BYTE;
         r_hburst     <= c_BURST_SINGLE;
         r_remain     <= '0;
         r_next_trans <= c_TRANS_SEQ;
         r_dp_valid   <= 1'b0;
         r_dp_write   <= 1'b0;
         r_rej        <= 1'b0;
      end else begin
         r_haddr      <= w_haddr_nxt;
         r_htrans     <= w_htrans_nxt;
         r_hwrite     <= w_hwrite_nxt;
         r_hsize      <= w_hsize_nxt;
         r_hburst     <= w_hburst_nxt;
         r_remain     <= w_remain_nxt;
         r_next_trans <= w_next_trans_nxt;
         r_dp_valid   <= w_dp_valid_nxt;
         r_dp_write   <= w_dp_write_nxt;
         r_rej        <= w_rej_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign o_haddr  = r_haddr;
   assign o_htrans = r_htrans;
   assign o_hwrite = r_hwrite;
   assign o_hsize  = r_hsize;
   assign o_hburst = r_hburst;
   assign o_hprot  = HPROT_VAL;

   // The core holds wdata until wdata_pop, so hwdata stays stable across waits.
   assign o_hwdata      = (r_dp_valid && r_dp_write) ? i_wdata : '0;
   assign o_wdata_pop   = w_dp_done && r_dp_write;
   assign o_rdata       = i_hrdata;
   assign o_rdata_valid = w_dp_done && !r_dp_write;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_burst_ctrl
// Purpose  : Directed self-checking bench for ahb_master_burst_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_master_burst_ctrl;

   localparam logic [1:0] IDL = 2'b00;
   localparam logic [1:0] BSY = 2'b01;
   localparam logic [1:0] NS  = 2'b10;
   localparam logic [1:0] SQ  = 2'b11;
   localparam logic [31:0] WBASE = 32'hCAFE_0000;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [2:0]  req_size;
   logic [2:0]  req_burst;
   logic [4:0]  req_len;
   logic        beat_stall;
   logic [31:0] wdata;
   logic        wdata_pop;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        done;
   logic        done_err;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready;
   logic        hresp;
   logic [31:0] hrdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 hclk = ~hclk;

   ahb_master_burst_ctrl #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .LEN_W    (5),
      .HPROT_VAL(4'b0011)
   ) dut (
      .i_hclk       (hclk),
      .i_hreset     (hreset),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_addr   (req_addr),
      .i_req_write  (req_write),
      .i_req_size   (req_size),
      .i_req_burst  (req_burst),
      .i_req_len    (req_len),
      .i_beat_stall (beat_stall),
      .i_wdata      (wdata),
      .o_wdata_pop  (wdata_pop),
      .o_rdata      (rdata),
      .o_rdata_valid(rdata_valid),
      .o_done       (done),
      .o_done_err   (done_err),
      .o_haddr      (haddr),
      .o_htrans     (htrans),
      .o_hwrite     (hwrite),
      .o_hsize      (hsize),
      .o_hburst     (hburst),
      .o_hprot      (hprot),
      .o_hwdata     (hwdata),
      .i_hready     (hready),
      .i_hresp      (hresp),
      .i_hrdata     (hrdata)
   );

   task automatic idle_inputs();
      req_valid  = 1'b0;
      req_addr   = '0;
      req_write  = 1'b0;
      req_size   = 3'd0;
      req_burst  = 3'd0;
      req_len    = 5'd0;
      beat_stall = 1'b0;
      wdata      = '0;
      hready     = 1'b1;
      hresp      = 1'b0;
      hrdata     = '0;
   endtask

   task automatic set_req(input logic [31:0] a, input logic w, input logic [2:0] s,
                          input logic [2:0] b, input logic [4:0] l);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      req_size  = s;
      req_burst = b;
      req_len   = l;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      hreset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge hclk);
      hreset = 1'b0;
      #1;
      n_checks++; if (htrans !== IDL) begin n_fail++; $display("FAIL reset_htrans: got %0h expected %0h", htrans, IDL); end
      n_checks++; if (haddr !== 32'h0) begin n_fail++; $display("FAIL reset_haddr: got %h expected 0", haddr); end
      n_checks++; if (hwrite !== 1'b0) begin n_fail++; $display("FAIL reset_hwrite: got %b expected 0", hwrite); end
      n_checks++; if (hsize !== 3'd0) begin n_fail++; $display("FAIL reset_hsize: got %0d expected 0", hsize); end
      n_checks++; if (hburst !== 3'd0) begin n_fail++; $display("FAIL reset_hburst: got %0d expected 0", hburst); end
      n_checks++; if (hprot !== 4'b0011) begin n_fail++; $display("FAIL reset_hprot: got %b expected 0011", hprot); end
      n_checks++; if (hwdata !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata: got %h expected 0", hwdata); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      n_checks++; if ({done, done_err, wdata_pop, rdata_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {done, done_err, wdata_pop, rdata_valid}); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_wrap4_read();
      logic [31:0] ea [4];
      logic [1:0]  et [4];
      int rv = 0;
      ea = '{32'h38, 32'h3C, 32'h30, 32'h34};
      et = '{NS, SQ, SQ, SQ};
      @(negedge hclk); set_req(32'h38, 1'b0, 3'd2, 3'd2, 5'd0); #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_req_ready: got %b expected 1", req_ready); end
      for (int i = 0; i < 4; i++) begin
         @(negedge hclk); req_valid = 1'b0; hrdata = 32'h1000 + i; #1;
         n_checks++; if (haddr !== ea[i]) begin n_fail++; $display("FAIL wrap_haddr beat %0d: got %h expected %h", i, haddr, ea[i]); end
         n_checks++; if (htrans !== et[i]) begin n_fail++; $display("FAIL wrap_htrans beat %0d: got %0h expected %0h", i, htrans, et[i]); end
         n_checks++; if (rdata_valid !== (i > 0)) begin n_fail++; $display("FAIL wrap_rdata_valid beat %0d: got %b expected %b", i, rdata_valid, (i > 0)); end
         if (rdata_valid === 1'b1) rv++;
         if (i == 0) begin
            n_checks++; if ({hburst, hsize, hwrite} !== {3'd2, 3'd2, 1'b0}) begin n_fail++; $display("FAIL wrap_ctrl: got %b expected %b", {hburst, hsize, hwrite}, {3'd2, 3'd2, 1'b0}); end
         end
      end
      // Final data phase: done, and a new request in this cycle must wait.
      @(negedge hclk); set_req(32'h80, 1'b0, 3'd2, 3'd0, 5'd0); hrdata = 32'h1004; #1;
      if (rdata_valid === 1'b1) rv++;
      n_checks++; if (htrans !== IDL) begin n_fail++; $display("FAIL wrap_last_htrans: got %0h expected %0h", htrans, IDL); end
      n_checks++; if ({done, done_err} !== 2'b10) begin n_fail++; $display("FAIL wrap_done: got %b expected 10", {done, done_err}); end
      n_checks++; if (rdata !== 32'h1004) begin n_fail++; $display("FAIL wrap_rdata: got %h expected 00001004", rdata); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_ready_on_done: got %b expected 0", req_ready); end
      n_checks++; if (rv !== 4) begin n_fail++; $display("FAIL wrap_rv_count: got %0d expected 4", rv); end
      @(negedge hclk); #1;
      n_checks++; if ({done, req_ready, htrans} !== {1'b0, 1'b1, IDL}) begin n_fail++; $display("FAIL wrap_after_done: got %b expected %b", {done, req_ready, htrans}, {1'b0, 1'b1, IDL}); end
      @(negedge hclk); req_valid = 1'b0; #1;
      n_checks++; if ({htrans, haddr, hburst} !== {NS, 32'h80, 3'd0}) begin n_fail++; $display("FAIL b2b_nonseq: got %h expected %h", {htrans, haddr, hburst}, {NS, 32'h80, 3'd0}); end
      @(negedge hclk); #1;
      n_checks++; if ({done, rdata_valid, htrans} !== {1'b1, 1'b1, IDL}) begin n_fail++; $display("FAIL b2b_single_done: got %b expected %b", {done, rdata_valid, htrans}, {1'b1, 1'b1, IDL}); end
      @(negedge hclk); idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_incr8_write_wait();
      logic [31:0] ea [11];
      logic [1:0]  et [11];
      logic        er [11];
      logic        ep [11];
      int          ew [11];
      int pops = 0;
      ea = '{32'h100, 32'h102, 32'h104, 32'h106, 32'h106, 32'h106, 32'h108, 32'h10A, 32'h10C, 32'h10E, 32'h10E};
      et = '{NS, SQ, SQ, SQ, SQ, SQ, SQ, SQ, SQ, SQ, IDL};
      er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      ep = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      ew = '{-1, 0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
      @(negedge hclk); set_req(32'h100, 1'b1, 3'd1, 3'd5, 5'd0); wdata = WBASE; #1;
      for (int i = 0; i < 11; i++) begin
         @(negedge hclk); req_valid = 1'b0; hready = er[i]; wdata = WBASE + pops; #1;
         n_checks++; if ({haddr, htrans} !== {ea[i], et[i]}) begin n_fail++; $display("FAIL incr8_addr cyc %0d: got %h/%0h expected %h/%0h", i, haddr, htrans, ea[i], et[i]); end
         n_checks++; if (hwdata !== ((ew[i] < 0) ? 32'h0 : (WBASE + ew[i]))) begin n_fail++; $display("FAIL incr8_hwdata cyc %0d: got %h expected index %0d", i, hwdata, ew[i]); end
         n_checks++; if (wdata_pop !== ep[i]) begin n_fail++; $display("FAIL incr8_pop cyc %0d: got %b expected %b", i, wdata_pop, ep[i]); end
         n_checks++; if ({done, done_err} !== ((i == 10) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL incr8_done cyc %0d: got %b", i, {done, done_err}); end
         if (wdata_pop === 1'b1) pops++;
      end
      n_checks++; if (pops !== 8) begin n_fail++; $display("FAIL incr8_pop_count: got %0d expected 8", pops); end
      @(negedge hclk); idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_incr_1k_cross();
      logic [31:0] ea [4];
      logic [1:0]  et [4];
      ea = '{32'h3FC, 32'h400, 32'h404, 32'h404};
      et = '{NS, NS, SQ, IDL};
      @(negedge hclk); set_req(32'h3FC, 1'b0, 3'd2, 3'd1, 5'd3); #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge hclk); req_valid = 1'b0; #1;
         n_checks++; if ({haddr, htrans} !== {ea[i], et[i]}) begin n_fail++; $display("FAIL incr1k cyc %0d: got %h/%0h expected %h/%0h", i, haddr, htrans, ea[i], et[i]); end
         n_checks++; if (done !== (i == 3)) begin n_fail++; $display("FAIL incr1k_done cyc %0d: got %b expected %b", i, done, (i == 3)); end
         if (i == 0) begin
            n_checks++; if (hburst !== 3'd1) begin n_fail++; $display("FAIL incr1k_hburst: got %0d expected 1", hburst); end
         end
      end
      @(negedge hclk); idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_error_abort();
      int pops = 0;
      @(negedge hclk); set_req(32'h200, 1'b1, 3'd2, 3'd3, 5'd0); wdata = WBASE; #1;
      @(negedge hclk); req_valid = 1'b0; #1;
      n_checks++; if ({haddr, htrans} !== {32'h200, NS}) begin n_fail++; $display("FAIL err_beat0: got %h/%0h expected 200/2", haddr, htrans); end
      if (wdata_pop === 1'b1) pops++;
      @(negedge hclk); #1;
      n_checks++; if ({haddr, htrans, wdata_pop} !== {32'h204, SQ, 1'b1}) begin n_fail++; $display("FAIL err_beat1: got %h/%0h/%b expected 204/3/1", haddr, htrans, wdata_pop); end
      if (wdata_pop === 1'b1) pops++;
      @(negedge hclk); wdata = WBASE + 1; hready = 1'b0; hresp = 1'b1; #1;
      n_checks++; if ({haddr, htrans, wdata_pop, done} !== {32'h208, SQ, 1'b0, 1'b0}) begin n_fail++; $display("FAIL err_first_cycle: got %h/%0h/%b/%b expected 208/3/0/0", haddr, htrans, wdata_pop, done); end
      if (wdata_pop === 1'b1) pops++;
      @(negedge hclk); hready = 1'b1; hresp = 1'b1; #1;
      n_checks++; if (htrans !== IDL) begin n_fail++; $display("FAIL err_htrans_idle: got %0h expected 0", htrans); end
      n_checks++; if ({done, done_err, wdata_pop} !== 3'b110) begin n_fail++; $display("FAIL err_done: got %b expected 110", {done, done_err, wdata_pop}); end
      if (wdata_pop === 1'b1) pops++;
      @(negedge hclk); hresp = 1'b0; #1;
      n_checks++; if ({htrans, done, req_ready} !== {IDL, 1'b0, 1'b1}) begin n_fail++; $display("FAIL err_recover: got %b expected 0001", {htrans, done, req_ready}); end
      n_checks++; if (pops !== 1) begin n_fail++; $display("FAIL err_pop_count: got %0d expected 1", pops); end
      idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_illegal();
      @(negedge hclk); set_req(32'h40, 1'b0, 3'd3, 3'd0, 5'd0); #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b expected 1", req_ready); end
      @(negedge hclk); set_req(32'h40, 1'b0, 3'd2, 3'd0, 5'd0); #1;
      n_checks++; if ({htrans, done, done_err, req_ready} !== {IDL, 3'b110}) begin n_fail++; $display("FAIL ill_size_reject: got %b expected 00110", {htrans, done, done_err, req_ready}); end
      @(negedge hclk); #1;
      n_checks++; if ({htrans, done, req_ready} !== {IDL, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ill_gap: got %b expected 0001", {htrans, done, req_ready}); end
      @(negedge hclk); req_valid = 1'b0; #1;
      n_checks++; if ({haddr, htrans} !== {32'h40, NS}) begin n_fail++; $display("FAIL ill_next_nonseq: got %h/%0h expected 40/2", haddr, htrans); end
      @(negedge hclk); #1;
      n_checks++; if ({done, done_err, htrans} !== {2'b10, IDL}) begin n_fail++; $display("FAIL ill_next_done: got %b expected 1000", {done, done_err, htrans}); end
      @(negedge hclk); set_req(32'h60, 1'b0, 3'd2, 3'd1, 5'd0); #1;
      @(negedge hclk); req_valid = 1'b0; #1;
      n_checks++; if ({htrans, done, done_err} !== {IDL, 2'b11}) begin n_fail++; $display("FAIL ill_len0_reject: got %b expected 0011", {htrans, done, done_err}); end
      @(negedge hclk); idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid_burst();
      @(negedge hclk); set_req(32'h500, 1'b1, 3'd2, 3'd7, 5'd0); wdata = WBASE; #1;
      @(negedge hclk); req_valid = 1'b0; #1;
      @(negedge hclk); #1;
      @(negedge hclk); #1;
      n_checks++; if ({haddr, htrans} !== {32'h508, SQ}) begin n_fail++; $display("FAIL rstmid_pre: got %h/%0h expected 508/3", haddr, htrans); end
      hreset = 1'b1;
      @(negedge hclk); #1;
      n_checks++; if ({haddr, htrans, hwrite, hsize, hburst} !== {32'h0, IDL, 1'b0, 3'd0, 3'd0}) begin n_fail++; $display("FAIL rstmid_ctrl: got %h/%0h/%b/%0d/%0d", haddr, htrans, hwrite, hsize, hburst); end
      n_checks++; if ({hwdata, wdata_pop, done, req_ready} !== {32'h0, 3'b001}) begin n_fail++; $display("FAIL rstmid_data: got %h/%b/%b/%b", hwdata, wdata_pop, done, req_ready); end
      hreset = 1'b0;
      @(negedge hclk); #1;
      n_checks++; if ({htrans, done, wdata_pop} !== {IDL, 2'b00}) begin n_fail++; $display("FAIL rstmid_after: got %b expected 0000", {htrans, done, wdata_pop}); end
      idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_busy();
`ifdef AHB_BUSY_EN
      localparam int N = 7;
      logic [31:0] ea [N];
      logic [1:0]  et [N];
      logic        ev [N];
      ea = '{32'h300, 32'h304, 32'h304, 32'h304, 32'h308, 32'h30C, 32'h30C};
      et = '{NS, BSY, BSY, SQ, SQ, SQ, IDL};
      ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
      localparam int N = 5;
      logic [31:0] ea [N];
      logic [1:0]  et [N];
      logic        ev [N];
      ea = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h30C};
      et = '{NS, SQ, SQ, SQ, IDL};
      ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
      @(negedge hclk); set_req(32'h300, 1'b0, 3'd2, 3'd3, 5'd0); #1;
      for (int i = 0; i < N; i++) begin
         @(negedge hclk); req_valid = 1'b0; beat_stall = (i < 2); #1;
         n_checks++; if ({haddr, htrans} !== {ea[i], et[i]}) begin n_fail++; $display("FAIL busy_addr cyc %0d: got %h/%0h expected %h/%0h", i, haddr, htrans, ea[i], et[i]); end
         n_checks++; if (rdata_valid !== ev[i]) begin n_fail++; $display("FAIL busy_rv cyc %0d: got %b expected %b", i, rdata_valid, ev[i]); end
         n_checks++; if (done !== (i == N - 1)) begin n_fail++; $display("FAIL busy_done cyc %0d: got %b expected %b", i, done, (i == N - 1)); end
      end
      @(negedge hclk); idle_inputs();
   endtask

   initial begin
      test_reset();
      test_wrap4_read();
      test_incr8_write_wait();
      test_incr_1k_cross();
      test_error_abort();
      test_illegal();
      test_reset_mid_burst();
      test_busy();
      repeat (2) @(negedge hclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/ahb_master_burst_ctrl.md
Name: ahb_master_burst_ctrl

Overview:
- AHB-Lite master-side burst sequencer that feeds the address/control bus typed by the team's AHB package (htrans_rtype, hsize_rtype, hburst_rtype).
- Accepts one burst command per handshake from a local core and emits NONSEQ/SEQ/IDLE/BUSY beats with correct INCR/WRAP address stepping.
- Tracks the data phase, honours hready wait states and aborts on a two-cycle ERROR response.
- Sits between core-side request logic and the AHB interconnect master port.

Parameters:
- ADDR_W, 32, haddr/req_addr width.
- DATA_W, 32, hwdata/hrdata width; hsize limited to BYTE/HALFWORD/WORD.
- LEN_W, 5, req_len width; beat count for INCR (undefined length) = req_len, legal range 1..2^LEN_W-1.
- HPROT_VAL, 4'b0011, constant driven on hprot.

Ports:
- hclk  in  1  bus clock; the only clock.
- hreset  in  1  synchronous active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_addr  in  ADDR_W  start address, aligned to req_size.
- req_write  in  1  1 = write burst.
- req_size  in  3  hsize_rtype.
- req_burst  in  3  hburst_rtype.
- req_len  in  LEN_W  beats for INCR; ignored otherwise.
- beat_stall  in  1  core not ready for next beat (see Optional Feature).
- wdata  in  DATA_W  write data for the current data phase.
- wdata_pop  out  1  pulse: write data phase completed; core advances wdata.
- rdata  out  DATA_W  read data.
- rdata_valid  out  1  pulse: rdata valid.
- done  out  1  pulse: burst finished.
- done_err  out  1  qualifies done: burst aborted or rejected.
- haddr  out  ADDR_W; htrans  out  2; hwrite  out  1; hsize  out  3; hburst  out  3; hprot  out  4; hwdata  out  DATA_W.
- hready  in  1; hresp  in  1; hrdata  in  DATA_W.

Behaviour:
- One clock (hclk); reset is synchronous and active-high (hreset).
- Reset values: htrans = IDLE, haddr = 0, hwrite = 0, hsize = BYTE, hburst = SINGLE, hprot = HPROT_VAL, hwdata = 0, req_ready = 1, all pulses = 0.
- Reset mid-burst drops the burst at the next edge; no done pulse.
- Address/control outputs are registered.
- FSM states: IDLE, ADDR, LAST, ERR.
- IDLE:
  - req_ready = 1.
  - On accept at edge T: haddr = req_addr, htrans = NONSEQ from T+1.
  - Beats = 1 for SINGLE, 4/8/16 for WRAPn/INCRn, req_len for INCR.
  - req_size > WORD or req_len = 0 with INCR: no bus activity; done = done_err = 1 at T+1.
- ADDR:
  - Outputs advance only on edges where hready = 1.
  - Next beat: htrans = SEQ, addr += (1 << hsize).
  - WRAP: next = (addr & ~(B-1)) | ((addr + inc) & (B-1)), with B = beats << hsize.
  - INCR/INCRn: if next address crosses a 1KB boundary (bit 10 changes), issue NONSEQ instead of SEQ.
  - After the last address phase is accepted, go to LAST with htrans = IDLE.
- Data phase (one beat behind the address phase) completes when hready = 1 and hresp = 0:
  - Write: hwdata = wdata during the data phase; wdata_pop pulses on completion.
  - Read: rdata = hrdata, rdata_valid pulses on completion.
- LAST: when the final data phase completes, done = 1 (done_err = 0) and return to IDLE. req_ready = 0 outside IDLE.
- ERROR:
  - hresp = 1 with hready = 0: htrans = IDLE from the next cycle, remaining beats cancelled, go to ERR.
  - Second cycle (hresp = 1, hready = 1): done = done_err = 1, go to IDLE.
  - No wdata_pop/rdata_valid for the errored beat.
- Simultaneous events:
  - A new req_valid in the same cycle as done is not accepted; earliest next NONSEQ is 2 cycles after done.
  - hready low holds haddr/htrans/hwdata stable.

Optional Feature:
- Macro AHB_BUSY_EN.
- Defined: beat_stall = 1 during ADDR after the first beat makes htrans = BUSY, with haddr/hburst holding the pending next-beat values.
  - Beat count is not advanced.
  - beat_stall is ignored on the NONSEQ beat and after the last beat has issued.
- Undefined: beat_stall is ignored and BUSY is never generated.

Test Plan:
- WRAP4 WORD read at 0x38, hready = 1: haddr 0x38, 0x3C, 0x30, 0x34; htrans NONSEQ, SEQ, SEQ, SEQ; 4 rdata_valid; done at last data phase.
- INCR8 HALFWORD write at 0x100 with hready low 2 cycles on beat 3: addresses 0x100..0x10E step 2, outputs frozen during wait, 8 wdata_pop, done_err = 0.
- INCR req_len = 3 WORD at 0x3FC: haddr 0x3FC NONSEQ, 0x400 NONSEQ (1KB cross), 0x404 SEQ.
- INCR4 write, ERROR on beat 2: htrans IDLE from cycle after hresp & !hready; exactly 1 wdata_pop; done = done_err = 1.
- Illegal: req_size = DOUBLEWORD → htrans stays IDLE, done = done_err = 1 one cycle after accept; hreset asserted mid-INCR16 → all outputs at reset values next edge.
- AHB_BUSY_EN: beat_stall high 2 cycles after beat 1 of INCR4 → htrans BUSY, BUSY, then SEQ at 0x+4; without macro, no BUSY.
